sc_compare_arbiter: RTL and testbench

SC_COMPARE_ARBITER -- requirements
Module: SC_COMPARE_ARBITER

---
 rtl/sc_compare_arbiter.sv | 91 +++++++++
 tb/tb_sc_compare_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sc_compare_arbiter.sv
// Two-requester arbiter sharing one external comparator.
// IDLE grants a requester, COMPARE drives the comparator, DONE acks.
module sc_compare_arbiter #(
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic                        SC_COMPARE_ARBITER_CLOCK_50,
    input  logic                        SC_COMPARE_ARBITER_RESET_InLow,
    input  logic                        SC_COMPARE_ARBITER_req0_In,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_COMPARE_ARBITER_dataA0_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_COMPARE_ARBITER_dataB0_InBUS,
    input  logic                        SC_COMPARE_ARBITER_req1_In,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_COMPARE_ARBITER_dataA1_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_COMPARE_ARBITER_dataB1_InBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_COMPARE_ARBITER_cmpA_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_COMPARE_ARBITER_cmpB_OutBUS,
    input  logic                        SC_COMPARE_ARBITER_cmpResult_In,
    output logic                        SC_COMPARE_ARBITER_ack0_Out,
    output logic                        SC_COMPARE_ARBITER_ack1_Out,
    output logic                        SC_COMPARE_ARBITER_result_Out,
    output logic                        SC_COMPARE_ARBITER_grant_Out,
    output logic                        SC_COMPARE_ARBITER_busy_Out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                      state, state_nxt;
    logic [NUMBER_DATAWIDTH-1:0] opa, opb;
    logic                        grant, last, result, win, any_req;

    assign any_req = SC_COMPARE_ARBITER_req0_In | SC_COMPARE_ARBITER_req1_In;

    // Tie goes to the requester that did not complete most recently.
    always_comb begin
        win = SC_COMPARE_ARBITER_req1_In;
        if (SC_COMPARE_ARBITER_req0_In && SC_COMPARE_ARBITER_req1_In)
            win = ~last;
    end

    always_ff @(posedge SC_COMPARE_ARBITER_CLOCK_50 or negedge SC_COMPARE_ARBITER_RESET_InLow) begin
        if (!SC_COMPARE_ARBITER_RESET_InLow) state <= IDLE;
        else                                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = any_req ? COMPARE : IDLE;
            COMPARE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge SC_COMPARE_ARBITER_CLOCK_50 or negedge SC_COMPARE_ARBITER_RESET_InLow) begin
        if (!SC_COMPARE_ARBITER_RESET_InLow) begin
            opa    <= '0;
            opb    <= '0;
            grant  <= 1'b0;
            result <= 1'b0;
            last   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    // Operands are snapshotted so later input changes cannot disturb the compare.
                    opa   <= win ? SC_COMPARE_ARBITER_dataA1_InBUS : SC_COMPARE_ARBITER_dataA0_InBUS;
                    opb   <= win ? SC_COMPARE_ARBITER_dataB1_InBUS : SC_COMPARE_ARBITER_dataB0_InBUS;
                    grant <= win;
                end
                COMPARE: result <= SC_COMPARE_ARBITER_cmpResult_In;
                DONE:    last   <= grant;
                default: ;
            endcase
        end
    end

    always_comb begin
        SC_COMPARE_ARBITER_ack0_Out = (state == DONE) && !grant;
        SC_COMPARE_ARBITER_ack1_Out = (state == DONE) &&  grant;
        SC_COMPARE_ARBITER_busy_Out = (state != IDLE);
    end

    assign SC_COMPARE_ARBITER_cmpA_OutBUS = opa;
    assign SC_COMPARE_ARBITER_cmpB_OutBUS = opb;
    assign SC_COMPARE_ARBITER_result_Out  = result;
    assign SC_COMPARE_ARBITER_grant_Out   = grant;

endmodule

// File: tb/tb_sc_compare_arbiter.sv
// Directed bench for sc_compare_arbiter with an expected-ack scoreboard
// and a behavioural comparator model that can be forced to report "differ".
module tb_sc_compare_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [W-1:0] cmp_a, cmp_b;
    logic         cmp_res, force_one;
    logic         ack0, ack1, result, grant, busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         idx;
        logic         res;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // External comparator: 1 when operands differ, or stuck at 1 when forced.
    always_comb cmp_res = force_one ? 1'b1 : (cmp_a != cmp_b);

    sc_compare_arbiter #(.NUMBER_DATAWIDTH(W)) dut (
        .SC_COMPARE_ARBITER_CLOCK_50     (clk),
        .SC_COMPARE_ARBITER_RESET_InLow  (rst_n),
        .SC_COMPARE_ARBITER_req0_In      (req0),
        .SC_COMPARE_ARBITER_dataA0_InBUS (a0),
        .SC_COMPARE_ARBITER_dataB0_InBUS (b0),
        .SC_COMPARE_ARBITER_req1_In      (req1),
        .SC_COMPARE_ARBITER_dataA1_InBUS (a1),
        .SC_COMPARE_ARBITER_dataB1_InBUS (b1),
        .SC_COMPARE_ARBITER_cmpA_OutBUS  (cmp_a),
        .SC_COMPARE_ARBITER_cmpB_OutBUS  (cmp_b),
        .SC_COMPARE_ARBITER_cmpResult_In (cmp_res),
        .SC_COMPARE_ARBITER_ack0_Out     (ack0),
        .SC_COMPARE_ARBITER_ack1_Out     (ack1),
        .SC_COMPARE_ARBITER_result_Out   (result),
        .SC_COMPARE_ARBITER_grant_Out    (grant),
        .SC_COMPARE_ARBITER_busy_Out     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic idx, input logic res, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.idx = idx; e.res = res; e.a = a; e.b = b;
        sb.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack0"},   {31'd0, ack0},   32'd0);
        chk({tag, "_ack1"},   {31'd0, ack1},   32'd0);
        chk({tag, "_busy"},   {31'd0, busy},   32'd0);
        chk({tag, "_grant"},  {31'd0, grant},  32'd0);
        chk({tag, "_result"}, {31'd0, result}, 32'd0);
        chk({tag, "_cmpA"},   {24'd0, cmp_a},  32'd0);
        chk({tag, "_cmpB"},   {24'd0, cmp_b},  32'd0);
    endtask

    // Grant edge: DUT must enter COMPARE with the expected winner's operands.
    task automatic grant_step(input string tag);
        tick();
        chk({tag, "_busy_cmp"}, {31'd0, busy}, 32'd1);
        if (sb.size() != 0) begin
            chk({tag, "_grant"}, {31'd0, grant}, {31'd0, sb[0].idx});
            chk({tag, "_cmpA"},  {24'd0, cmp_a}, {24'd0, sb[0].a});
            chk({tag, "_cmpB"},  {24'd0, cmp_b}, {24'd0, sb[0].b});
        end
    endtask

    // Waits (bounded) for an ack, checks its latency and pops the scoreboard.
    task automatic wait_ack(input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (!(ack0 || ack1) && lat < 6) begin
            tick();
            lat++;
        end
        if (!(ack0 || ack1)) begin
            chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected_ack"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, lat,                   exp_lat);
            chk({tag, "_ack0"},    {31'd0, ack0},         {31'd0, ~e.idx});
            chk({tag, "_ack1"},    {31'd0, ack1},         {31'd0, e.idx});
            chk({tag, "_grant"},   {31'd0, grant},        {31'd0, e.idx});
            chk({tag, "_result"},  {31'd0, result},       {31'd0, e.res});
            chk({tag, "_busy"},    {31'd0, busy},         32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; force_one = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #1;
        chk_reset_outputs("por");
        tick(); tick();
        rst_n = 1'b1;

        // Single requester 0, equal operands.
        req0 = 1'b1; a0 = 8'd5; b0 = 8'd5;
        push(1'b0, 1'b0, 8'd5, 8'd5);
        grant_step("r0_eq");
        wait_ack("r0_eq", 1);
        req0 = 1'b0;
        tick();
        chk("r0_idle_busy",   {31'd0, busy},   32'd0);
        chk("r0_hold_result", {31'd0, result}, 32'd0);
        chk("r0_hold_cmpA",   {24'd0, cmp_a},  32'd5);

        // Single requester 1, differing operands.
        req1 = 1'b1; a1 = 8'd3; b1 = 8'd7;
        push(1'b1, 1'b1, 8'd3, 8'd7);
        grant_step("r1_ne");
        wait_ack("r1_ne", 1);
        req1 = 1'b0;
        tick();
        chk("r1_hold_result", {31'd0, result}, 32'd1);
        chk("r1_hold_grant",  {31'd0, grant},  32'd1);
        chk("r1_idle_ack1",   {31'd0, ack1},   32'd0);

        // Fresh reset, then both held high: round-robin starting at 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a0 = 8'd1; b0 = 8'd2; a1 = 8'd4; b1 = 8'd4;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(1'b0, 1'b1, 8'd1, 8'd2);
            else            push(1'b1, 1'b0, 8'd4, 8'd4);
            if (i != 0) begin
                tick();
                chk("rr_gap_busy", {31'd0, busy}, 32'd0);
            end
            grant_step("rr");
            wait_ack("rr", 1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Operand change after grant must not affect the compare.
        req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
        push(1'b0, 1'b0, 8'd9, 8'd9);
        grant_step("snap");
        a0 = 8'd4;
        req0 = 1'b0;
        wait_ack("snap", 1);
        tick();

        // Reset during COMPARE of requester 1 aborts it.
        req1 = 1'b1; a1 = 8'd1; b1 = 8'd2;
        tick();
        chk("abort_busy_cmp",  {31'd0, busy},  32'd1);
        chk("abort_grant_cmp", {31'd0, grant}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        tick();
        chk("abort_hold_ack1", {31'd0, ack1}, 32'd0);
        req0 = 1'b1; a0 = 8'd6; b0 = 8'd6;
        rst_n = 1'b1;
        push(1'b0, 1'b0, 8'd6, 8'd6);
        grant_step("post_rst");
        wait_ack("post_rst", 1);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Forced comparator: result must follow cmpResult_In.
        force_one = 1'b1;
        req0 = 1'b1; a0 = 8'd7; b0 = 8'd7;
        push(1'b0, 1'b1, 8'd7, 8'd7);
        grant_step("forced");
        wait_ack("forced", 1);
        req0 = 1'b0;
        force_one = 1'b0;
        tick();
        chk("forced_hold_result", {31'd0, result}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
